polar_encoder: RTL and testbench

Serial-in/serial-out polar encoder that forms the transmit side of the SC decoder chain. It accepts K information bits one per cycle and places them at the information positions of a length-N frame, with frozen positions forced to 0. It computes x = u·F^{⊗n} with F = [[1,0],[1,1]] in natural (non-bit-reversed) order, then streams the N codeword bits out one per cycle. Its frozen-mask convention matches the decoder's `frozen_bit_indication`: 1 marks an information position, 0 a frozen position.

---
 rtl/polar_pkg.sv | 35 +++
 rtl/polar_encoder_if.sv | 22 ++
 rtl/polar_butterfly_stage.sv | 26 ++
 rtl/polar_encoder.sv | 106 ++++++++++
 tb/tb_polar_encoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/polar_pkg.sv
// Shared polar-code helpers: FSM state encoding and frozen-mask walking.
// Reused by both the encoder and the SC decoder for information-set handling.
package polar_pkg;

  localparam int MAX_N = 256;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  function automatic int popcount(input logic [MAX_N-1:0] mask);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (mask[i]) cnt++;
    end
    return cnt;
  endfunction

  // Next set bit strictly above idx; wraps to the lowest set bit when none is left.
  function automatic int next_info_idx(input logic [MAX_N-1:0] mask, input int idx);
    int first;
    int nxt;
    first = -1;
    nxt   = -1;
    for (int i = 0; i < MAX_N; i++) begin
      if (mask[i] && first < 0) first = i;
      if (mask[i] && i > idx && nxt < 0) nxt = i;
    end
    return (nxt >= 0) ? nxt : first;
  endfunction

endpackage

// File: rtl/polar_encoder_if.sv
// Serial information-bit input and codeword-bit output handshakes of the polar encoder.
// master drives bits in and accepts codeword bits; slave is the encoder side.
interface polar_encoder_if;
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic busy;

  modport master (
    output in_bit, in_valid, out_ready,
    input  in_ready, out_bit, out_valid, out_last, busy
  );

  modport slave (
    input  in_bit, in_valid, out_ready,
    output in_ready, out_bit, out_valid, out_last, busy
  );
endinterface

// File: rtl/polar_butterfly_stage.sv
// One butterfly stage of x = u * F^{(x)n}, natural order; purely combinational, zero latency.
// Pairs (i, i + 2^stage) with bit 'stage' of i clear get u[i] ^= u[i + 2^stage].
module polar_butterfly_stage #(
  parameter int N       = 8,
  parameter int STAGE_W = 2
) (
  input  logic [N-1:0]       u,
  input  logic [STAGE_W-1:0] stage,
  output logic [N-1:0]       u_next
);

  localparam int LOG_N = $clog2(N);

  always_comb begin
    u_next = u;
    for (int s = 0; s < LOG_N; s++) begin
      if (int'(stage) == s) begin
        for (int i = 0; i < N; i++) begin
          // i ^ 2^s equals i + 2^s here and never leaves the vector
          if (((i >> s) & 1) == 0) u_next[i] = u[i] ^ u[i ^ (1 << s)];
        end
      end
    end
  end

endmodule

// File: rtl/polar_encoder.sv
// Serial polar encoder: K info bits in, log2(N) butterfly cycles, N codeword bits out.
// Frame period K + log2(N) + N cycles; input stalls outside LOAD, output holds on out_ready low.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = 8,
  parameter int           K           = 4,
  parameter logic [N-1:0] FROZEN_MASK = 8'b1110_1000
) (
  input logic            clk,
  input logic            rst,
  polar_encoder_if.slave bus
);

  localparam int LOG_N   = $clog2(N);
  localparam int IDX_W   = $clog2(N);
  localparam int STAGE_W = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  localparam logic [MAX_N-1:0]   MASK_EXT   = MAX_N'(FROZEN_MASK);
  localparam logic [IDX_W-1:0]   FIRST_IDX  = IDX_W'(next_info_idx(MASK_EXT, -1));
  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG_N - 1);

  if (N < 2 || (N & (N - 1)) != 0 || N > MAX_N) begin : g_bad_n
    $error("polar_encoder: N must be a power of two between 2 and MAX_N");
  end
  if (K < 1 || K > N || popcount(MASK_EXT) != K) begin : g_bad_k
    $error("polar_encoder: popcount(FROZEN_MASK) must equal K, with 1 <= K <= N");
  end

  state_t             state;
  state_t             state_nxt;
  logic [N-1:0]       u;
  logic [N-1:0]       u_stage;
  logic [IDX_W-1:0]   p;
  logic [IDX_W-1:0]   p_nxt;
  logic               last_info;
  logic [STAGE_W-1:0] stage;
  logic [IDX_W-1:0]   j;

  polar_butterfly_stage #(
    .N       (N),
    .STAGE_W (STAGE_W)
  ) u_bfly (
    .u      (u),
    .stage  (stage),
    .u_next (u_stage)
  );

  always_comb begin
    state_nxt = state;
    p_nxt     = IDX_W'(next_info_idx(MASK_EXT, int'(p)));
    // The walk wrapping back to a lower index means p holds the K-th info position
    last_info = (p_nxt <= p);
    case (state)
      ST_LOAD:   if (bus.in_valid && last_info) state_nxt = ST_ENCODE;
      ST_ENCODE: if (stage == LAST_STAGE) state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (bus.out_ready && j == LAST_IDX) state_nxt = ST_LOAD;
      default:   state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_LOAD;
      u     <= '0;
      p     <= FIRST_IDX;
      stage <= '0;
      j     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_LOAD: begin
          if (bus.in_valid) begin
            u[p] <= bus.in_bit;
            p    <= p_nxt;
          end
        end
        ST_ENCODE: begin
          u     <= u_stage;
          stage <= (stage == LAST_STAGE) ? '0 : stage + STAGE_W'(1);
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            if (j == LAST_IDX) begin
              // Clearing u here is what keeps frozen positions at 0 next frame
              u <= '0;
              p <= FIRST_IDX;
              j <= '0;
            end else begin
              j <= j + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == ST_LOAD);
  assign bus.out_valid = (state == ST_OUTPUT);
  assign bus.out_bit   = (state == ST_OUTPUT) & u[j];
  assign bus.out_last  = (state == ST_OUTPUT) && (j == LAST_IDX);
  assign bus.busy      = (state != ST_LOAD);

endmodule

// File: tb/tb_polar_encoder.sv
// Scoreboard bench for polar_encoder: default N=8 instance plus an N=4, K=N instance.
// Expected codewords are hand-derived from x_j = XOR of u_i over all i whose bits cover j.
module tb_polar_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  polar_encoder_if a_if ();
  polar_encoder_if b_if ();

  polar_encoder #(.N(8), .K(4), .FROZEN_MASK(8'b1110_1000)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (a_if.slave)
  );

  polar_encoder #(.N(4), .K(4), .FROZEN_MASK(4'b1111)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  int         hs_a = 0;
  int         hs_b = 0;
  int         in_t_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: compare every output handshake against the head of the queue
  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_a && a_if.out_valid && a_if.out_ready) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_output", exp_a.size(), 1);
      end else begin
        e = exp_a.pop_front();
        check($sformatf("a_bit_hs%0d", hs_a), a_if.out_bit, e[1]);
        check($sformatf("a_last_hs%0d", hs_a), a_if.out_last, e[0]);
      end
      hs_a++;
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst_b && b_if.in_valid && b_if.in_ready) in_t_b.push_back(cyc);
    if (!rst_b && b_if.out_valid && b_if.out_ready) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_output", exp_b.size(), 1);
      end else begin
        e = exp_b.pop_front();
        check($sformatf("b_bit_hs%0d", hs_b), b_if.out_bit, e[1]);
        check($sformatf("b_last_hs%0d", hs_b), b_if.out_last, e[0]);
      end
      hs_b++;
    end
  end

  // x is LSB-first: x[0] is the first codeword bit
  task automatic push_a(input logic [7:0] x, input int cnt);
    for (int i = 0; i < cnt; i++) exp_a.push_back({x[i], 1'(i == 7)});
  endtask

  task automatic load_a(input logic [3:0] bits, input bit rnd);
    int   idx;
    int   guard;
    logic acc;
    idx   = 0;
    guard = 0;
    while (idx < 4 && guard < 200) begin
      a_if.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a_if.in_bit   = bits[idx];
      acc = a_if.in_valid && a_if.in_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    a_if.in_valid = 1'b0;
    a_if.in_bit   = 1'b0;
    check("a_load_accepted", idx, 4);
  endtask

  task automatic drain_a(input string tag);
    int guard;
    guard = 0;
    while (exp_a.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_drained"}, exp_a.size(), 0);
    check({tag, "_in_ready_after"}, a_if.in_ready, 1);
    check({tag, "_busy_after"}, a_if.busy, 0);
  endtask

  task automatic wait_hs_a(input int target, input int base, input string tag);
    int guard;
    guard = 0;
    while (!(a_if.out_valid && (hs_a - base) == target) && guard < 100) begin
      tick();
      guard++;
    end
    check({tag, "_reached_j"}, hs_a - base, target);
  endtask

  initial begin
    int         base;
    int         idx;
    int         guard;
    logic       acc;
    logic [7:0] b_bits;

    rst_a = 1'b1;
    rst_b = 1'b1;
    a_if.in_bit = 1'b0; a_if.in_valid = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_bit = 1'b0; b_if.in_valid = 1'b0; b_if.out_ready = 1'b1;
    repeat (3) tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    check("rst_in_ready", a_if.in_ready, 1);
    check("rst_out_valid", a_if.out_valid, 0);
    check("rst_out_last", a_if.out_last, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_out_bit", a_if.out_bit, 0);

    // u3 = 1 -> 1,1,1,1,0,0,0,0; also checks ENCODE length
    push_a(8'b0000_1111, 8);
    load_a(4'b0001, 1'b0);
    check("enc_busy", a_if.busy, 1);
    check("enc_in_ready", a_if.in_ready, 0);
    repeat (2) tick();
    check("enc_last_stage_out_valid", a_if.out_valid, 0);
    tick();
    check("enc_done_out_valid", a_if.out_valid, 1);
    drain_a("single_first");

    // u7 = 1 -> all ones
    push_a(8'b1111_1111, 8);
    load_a(4'b1000, 1'b0);
    drain_a("single_last");

    // all info bits set -> 0,1,1,0,1,0,0,1
    push_a(8'b1001_0110, 8);
    load_a(4'b1111, 1'b0);
    drain_a("all_ones");

    // u5 = u6 = 1 -> 0,1,1,0,0,1,1,0 with random input gaps and a stall at j=2
    base = hs_a;
    push_a(8'b0110_0110, 8);
    load_a(4'b0110, 1'b1);
    wait_hs_a(2, base, "bp");
    a_if.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_hold_bit_%0d", k), a_if.out_bit, 1);
      check($sformatf("bp_hold_last_%0d", k), a_if.out_last, 0);
      check($sformatf("bp_hold_valid_%0d", k), a_if.out_valid, 1);
      check($sformatf("bp_in_ready_%0d", k), a_if.in_ready, 0);
      tick();
    end
    a_if.out_ready = 1'b1;
    drain_a("bp");
    check("bp_handshake_count", hs_a - base, 8);

    // u5 = 1 -> 1,1,0,0,1,1,... aborted by reset while x5 is presented
    base = hs_a;
    push_a(8'b0011_0011, 5);
    load_a(4'b0010, 1'b0);
    wait_hs_a(5, base, "rst_mid");
    rst_a = 1'b1;
    a_if.out_ready = 1'b0;
    tick();
    rst_a = 1'b0;
    a_if.out_ready = 1'b1;
    check("rst_mid_out_valid", a_if.out_valid, 0);
    check("rst_mid_in_ready", a_if.in_ready, 1);
    check("rst_mid_busy", a_if.busy, 0);
    check("rst_mid_queue", exp_a.size(), 0);
    push_a(8'b0000_1111, 8);
    load_a(4'b0001, 1'b0);
    drain_a("after_rst");

    // N=4, K=4: frames 0,1,0,0 -> 1,1,0,0 and 0,0,1,1 -> 0,1,0,1, back to back
    for (int i = 0; i < 4; i++) exp_b.push_back({1'(4'b0011 >> i), 1'(i == 3)});
    for (int i = 0; i < 4; i++) exp_b.push_back({1'(4'b1010 >> i), 1'(i == 3)});
    b_bits = 8'b1100_0010;
    idx   = 0;
    guard = 0;
    while (idx < 8 && guard < 200) begin
      b_if.in_valid = 1'b1;
      b_if.in_bit   = b_bits[idx];
      acc = b_if.in_valid && b_if.in_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    b_if.in_valid = 1'b0;
    b_if.in_bit   = 1'b0;
    check("b_load_accepted", idx, 8);
    guard = 0;
    while (exp_b.size() > 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("b_drained", exp_b.size(), 0);
    check("b_accept_count", in_t_b.size(), 8);
    if (in_t_b.size() == 8) begin
      check("b_frame_period", in_t_b[4] - in_t_b[0], 10);
      check("b_input_burst", in_t_b[7] - in_t_b[4], 3);
    end

    repeat (2) tick();
    check("a_queue_empty_end", exp_a.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
